// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one signed 18x16 Q15 multiplier among N_REQ requesters.
// Two registered stages (operands, result) with valid/ready backpressure on the result port.
module mul_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [18*N_REQ-1:0]   a_in,
  input  logic [16*N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]      gnt,
  output logic [15:0]           q_out,
  output logic                  q_valid,
  output logic [ID_W-1:0]       q_id,
  input  logic                  q_ready,
  output logic                  busy
);

  logic                    advance;
  logic [ID_W-1:0]         ptr;
  logic [ID_W-1:0]         ptr_nxt;
  logic [ID_W-1:0]         gnt_idx;
  logic [ID_W-1:0]         idx;
  logic                    found;

  logic                    v1;
  logic signed [17:0]      opa;
  logic signed [15:0]      opb;
  logic [ID_W-1:0]         id1;

  logic signed [33:0]      prod;
  logic                    unused_prod;

  assign advance = !q_valid || q_ready;
  assign busy    = v1 | q_valid;

  // Intended to map onto a single DSP between the two pipeline stages.
  assign prod        = opa * opb;
  assign unused_prod = ^{prod[32:30], prod[14:0]};

  // Search from ptr upward (mod N_REQ); grant is suppressed while stalled or in reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (rst_n && advance) begin
      for (int k = 0; k < int'(N_REQ); k++) begin
        idx = ID_W'((int'(ptr) + k) % int'(N_REQ));
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_nxt = (int'(gnt_idx) == int'(N_REQ) - 1) ? '0 : gnt_idx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      id1     <= '0;
      ptr     <= '0;
      q_valid <= 1'b0;
      q_out   <= '0;
      q_id    <= '0;
    end else if (advance) begin
      q_valid <= v1;
      q_out   <= {prod[33], prod[29:15]};
      q_id    <= id1;
      v1      <= found;
      if (found) begin
        opa <= a_in[int'(gnt_idx)*18 +: 18];
        opb <= b_in[int'(gnt_idx)*16 +: 16];
        id1 <= gnt_idx;
        ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: doc/mul_rr_arbiter.md
Name: mul_rr_arbiter

Overview:
- Shares one signed 18x16 fixed-point multiplier among N_REQ requesters in the LeNet datapath, for example conv and fc lanes that do not each need a dedicated DSP.
- Arbitration is round-robin, with a two-stage registered pipeline:
  - stage 1 holds the latched operands;
  - stage 2 holds the truncated Q-format result.
- Output is a valid/ready result port tagged with the requester ID. Backpressure stalls the pipeline without losing data.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must equal clog2(N_REQ)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req  in  N_REQ  per-requester request; held with operands until granted
a_in  in  18*N_REQ  signed operand A, requester i at [18i+17:18i]
b_in  in  16*N_REQ  signed operand B, requester i at [16i+15:16i]
gnt  out  N_REQ  combinational one-hot grant; operands of i captured at this clock edge
q_out  out  16  signed result, registered
q_valid  out  1  q_out/q_id valid
q_id  out  ID_W  index of requester that owns q_out
q_ready  in  1  downstream accepts result when q_valid&&q_ready
busy  out  1  v1|q_valid (any operation in flight)

Behaviour:
- Reset (rst_n low, async):
  - v1, q_valid, q_out, q_id, operand regs are 0; rr pointer ptr=0; gnt=0 while in reset.
  - In-flight operations are discarded. No stale q_valid appears after release.
- advance = !q_valid || q_ready.
- When advance=1, on each rising edge:
  - stage 2 loads from stage 1: q_valid<=v1, q_out<=mul(opA,opB), q_id<=id1.
  - stage 1 loads the new grant: v1<=|gnt, opA/opB/id1 <= granted requester's operands.
- When advance=0: all registers hold and gnt is forced to 0.
- Arbitration (combinational), only when advance=1:
  - Search indices ptr, ptr+1, ... mod N_REQ; grant the first asserted req.
  - At most one gnt bit is set per cycle.
- Pointer update:
  - On the edge where gnt[i]=1, ptr<=(i+1) mod N_REQ.
  - No grant means ptr is unchanged.
- Requester handshake: a requester sees gnt[i]=1 in the cycle its operands are sampled. It may change or drop req/operands in the next cycle. gnt is never asserted for a deasserted req bit.
- Throughput and latency:
  - Throughput is one grant per cycle.
  - Latency: grant in cycle t gives q_valid in cycle t+2 (unstalled).
  - Order of results equals order of grants.
- Arithmetic:
  - p = signed(opA) * signed(opB), 34-bit.
  - q = {p[33], p[29:15]}: Q15 truncation with no rounding and no saturation. p[32:30] are discarded, so overflow wraps.
  - The multiply is combinational between stage 1 and stage 2, intended to map to one DSP.
- Boundary conditions:
  - req all zero: v1 clears on the next advancing edge and the pipeline drains normally.
  - Stall with stage 1 full and q_valid high: both hold. Nothing is overwritten or duplicated.
  - q_valid&&q_ready with a new grant in the same cycle: all three transfers occur on the same edge.
  - Reset asserted mid-stall: all state is cleared immediately.

Test Plan:
1. Single op: req=0001, a0=32768, b0=16384. Expected: gnt=0001 in cycle 0; in cycle 2, q_valid=1, q_out=16384 (0x4000), q_id=0; busy=0 by cycle 3 if q_ready=1.
2. Negative and wrap:
   - a=-32768, b=16384 gives q_out=0xC000 (-16384).
   - a=131071, b=32767 gives q_out=0x7FFB (32763, truncated, no saturation).
3. Round-robin:
   - req=1111 held with q_ready=1: gnt sequence 0001,0010,0100,1000,0001; q_id sequence 0,1,2,3,0 offset by 2 cycles.
   - Then with ptr=2 and req=1001: grant goes to requester 3, then requester 0.
4. Backpressure:
   - req=1111, q_ready=0 for 3 cycles while q_valid=1: gnt=0000, q_out/q_id/opA held.
   - After release: no result is lost or duplicated; q_id order continues 0,1,2,3.
5. Drain/idle: a burst of 3 grants then req=0 gives exactly 3 q_valid pulses. busy falls the cycle after the last accepted result; ptr stays at last grant+1.
6. Reset mid-operation: rst_n low asynchronously while v1=1 and q_valid=1 gives q_valid=0, gnt=0 immediately. After release with req=0, no q_valid appears; the first new grant goes to requester 0.
